// File: rtl/conv2d_core_acc.sv
// Convolution core: per-beat data x weight products, channel reduction, windowed
// accumulation per kernel, then arithmetic shift, optional ReLU and saturation.
module conv2d_core_acc #(
    parameter int BIT_WIDTH   = 8,
    parameter int NUM_CHANNEL = 3,
    parameter int NUM_KERNEL  = 4,
    parameter int ACC_WIDTH   = 32,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [CNT_WIDTH-1:0]                        i_conf_cnt,
    input  logic [4:0]                                  i_conf_shift,
    input  logic                                        i_conf_relu,
    input  logic                                        i_conf_val,
    input  logic [BIT_WIDTH*NUM_CHANNEL-1:0]            i_data,
    input  logic                                        i_data_val,
    input  logic [BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] i_weight,
    input  logic                                        i_weight_val,
    output logic                                        o_ready,
    output logic [BIT_WIDTH*NUM_KERNEL-1:0]             o_psum,
    output logic                                        o_psum_val,
    output logic [NUM_KERNEL-1:0]                       o_sat,
    output logic                                        o_conf_err
);

    localparam int PROD_W = 2 * BIT_WIDTH;
    localparam int SUM_W  = PROD_W + $clog2(NUM_CHANNEL);
    localparam int W_W    = BIT_WIDTH * NUM_CHANNEL * NUM_KERNEL;
    localparam logic signed [ACC_WIDTH-1:0] PSUM_MAX = ACC_WIDTH'((1 << (BIT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] PSUM_MIN = ~PSUM_MAX;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    state_e                       state_q, state_d;
    logic                         conf_accept, conf_reject, beat_accept, pipe_idle;
    logic [CNT_WIDTH-1:0]         n_q, n_d, cnt_q, cnt_d;
    logic [4:0]                   shift_q, shift_d;
    logic                         relu_q, relu_d;
    logic [W_W-1:0]               w_q, w_d;
    logic                         beat_first, beat_last;

    logic                         s1_val_q, s1_first_q, s1_last_q;
    logic signed [PROD_W-1:0]     prod_d [NUM_KERNEL][NUM_CHANNEL];
    logic signed [PROD_W-1:0]     prod_q [NUM_KERNEL][NUM_CHANNEL];
    logic                         s2_val_q, s2_last_q;
    logic signed [ACC_WIDTH-1:0]  acc_d [NUM_KERNEL];
    logic signed [ACC_WIDTH-1:0]  acc_q [NUM_KERNEL];
    logic                         s3_val_q;
    logic signed [ACC_WIDTH-1:0]  r_d [NUM_KERNEL];
    logic signed [ACC_WIDTH-1:0]  r_q [NUM_KERNEL];

    logic [BIT_WIDTH*NUM_KERNEL-1:0] psum_d, psum_q;
    logic [NUM_KERNEL-1:0]           sat_hit, sat_d, sat_q;
    logic                            psum_val_q, conf_err_q;

    // A config reload is only safe between windows with nothing left to accumulate.
    assign pipe_idle = (cnt_q == '0) && !s1_val_q && !s2_val_q;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        o_ready     = 1'b0;
        conf_accept = 1'b0;
        conf_reject = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_conf_val) begin
                    conf_accept = 1'b1;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                o_ready = 1'b1;
                if (i_conf_val) begin
                    conf_accept = pipe_idle;
                    conf_reject = !pipe_idle;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        n_d     = n_q;
        shift_d = shift_q;
        relu_d  = relu_q;
        if (conf_accept) begin
            n_d     = (i_conf_cnt == '0) ? CNT_WIDTH'(1) : i_conf_cnt;
            shift_d = i_conf_shift;
            relu_d  = i_conf_relu;
        end
        beat_accept = i_data_val && o_ready;
        beat_first  = (cnt_q == '0);
        beat_last   = (cnt_q == n_d - CNT_WIDTH'(1));
        cnt_d       = cnt_q;
        if (beat_accept) begin
            cnt_d = beat_last ? '0 : cnt_q + CNT_WIDTH'(1);
        end
        w_d = i_weight_val ? i_weight : w_q;
    end

    // Products use w_d so a weight load in the same cycle as a beat takes effect at once.
    always_comb begin
        for (int k = 0; k < NUM_KERNEL; k++) begin
            for (int c = 0; c < NUM_CHANNEL; c++) begin
                prod_d[k][c] = PROD_W'($signed(w_d[(k*NUM_CHANNEL+c)*BIT_WIDTH +: BIT_WIDTH]))
                             * PROD_W'($signed(i_data[c*BIT_WIDTH +: BIT_WIDTH]));
            end
        end
    end

    always_comb begin : stage2_comb
        logic signed [SUM_W-1:0] sum;
        for (int k = 0; k < NUM_KERNEL; k++) begin
            sum = '0;
            for (int c = 0; c < NUM_CHANNEL; c++) begin
                sum = sum + SUM_W'(prod_q[k][c]);
            end
            acc_d[k] = s1_first_q ? ACC_WIDTH'(sum) : acc_q[k] + ACC_WIDTH'(sum);
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_KERNEL; k++) begin
            r_d[k] = acc_q[k] >>> shift_q;
            if (relu_q && r_d[k][ACC_WIDTH-1]) begin
                r_d[k] = '0;
            end
        end
    end

    always_comb begin
        psum_d  = psum_q;
        sat_hit = '0;
        for (int k = 0; k < NUM_KERNEL; k++) begin
            if (r_q[k] > PSUM_MAX) begin
                psum_d[k*BIT_WIDTH +: BIT_WIDTH] = PSUM_MAX[BIT_WIDTH-1:0];
                sat_hit[k] = 1'b1;
            end else if (r_q[k] < PSUM_MIN) begin
                psum_d[k*BIT_WIDTH +: BIT_WIDTH] = PSUM_MIN[BIT_WIDTH-1:0];
                sat_hit[k] = 1'b1;
            end else begin
                psum_d[k*BIT_WIDTH +: BIT_WIDTH] = r_q[k][BIT_WIDTH-1:0];
            end
        end
        // A new config starts a fresh sticky history.
        sat_d = conf_accept ? '0 : (sat_q | (s3_val_q ? sat_hit : '0));
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            cnt_q      <= '0;
            w_q        <= '0;
            s1_val_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_val_q   <= 1'b0;
            s2_last_q  <= 1'b0;
            s3_val_q   <= 1'b0;
            psum_q     <= '0;
            psum_val_q <= 1'b0;
            sat_q      <= '0;
            conf_err_q <= 1'b0;
            // NOTE: the datapath arrays are reset too, so a reset mid-window
            // leaves no stale partial sums behind.
            for (int k = 0; k < NUM_KERNEL; k++) begin
                acc_q[k] <= '0;
                r_q[k]   <= '0;
                for (int c = 0; c < NUM_CHANNEL; c++) begin
                    prod_q[k][c] <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            shift_q    <= shift_d;
            relu_q     <= relu_d;
            cnt_q      <= cnt_d;
            w_q        <= w_d;
            s1_val_q   <= beat_accept;
            s1_first_q <= beat_first;
            s1_last_q  <= beat_last;
            if (beat_accept) begin
                prod_q <= prod_d;
            end
            s2_val_q  <= s1_val_q;
            s2_last_q <= s1_val_q && s1_last_q;
            if (s1_val_q) begin
                acc_q <= acc_d;
            end
            s3_val_q <= s2_val_q && s2_last_q;
            if (s2_val_q && s2_last_q) begin
                r_q <= r_d;
            end
            psum_val_q <= s3_val_q;
            if (s3_val_q) begin
                psum_q <= psum_d;
            end
            sat_q      <= sat_d;
            conf_err_q <= conf_reject;
        end
    end

    assign o_psum     = psum_q;
    assign o_psum_val = psum_val_q;
    assign o_sat      = sat_q;
    assign o_conf_err = conf_err_q;

endmodule

// File: tb/tb_conv2d_core_acc.sv
// Self-checking bench for conv2d_core_acc: directed cases plus randomized windows
// scored against an arithmetic window model with expected output cycle.
module tb_conv2d_core_acc;

    localparam int BW = 8;
    localparam int NC = 3;
    localparam int NK = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      i_conf_cnt;
    logic [4:0]      i_conf_shift;
    logic            i_conf_relu;
    logic            i_conf_val;
    logic [BW*NC-1:0]    i_data;
    logic            i_data_val;
    logic [BW*NC*NK-1:0] i_weight;
    logic            i_weight_val;
    logic            o_ready;
    logic [BW*NK-1:0] o_psum;
    logic            o_psum_val;
    logic [NK-1:0]   o_sat;
    logic            o_conf_err;

    conv2d_core_acc #(
        .BIT_WIDTH  (BW),
        .NUM_CHANNEL(NC),
        .NUM_KERNEL (NK),
        .ACC_WIDTH  (32),
        .CNT_WIDTH  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_conf_cnt  (i_conf_cnt),
        .i_conf_shift(i_conf_shift),
        .i_conf_relu (i_conf_relu),
        .i_conf_val  (i_conf_val),
        .i_data      (i_data),
        .i_data_val  (i_data_val),
        .i_weight    (i_weight),
        .i_weight_val(i_weight_val),
        .o_ready     (o_ready),
        .o_psum      (o_psum),
        .o_psum_val  (o_psum_val),
        .o_sat       (o_sat),
        .o_conf_err  (o_conf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW*NK-1:0] psum;
        logic [NK-1:0]    sat;
        int               due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    // Reference model state
    int       m_w[NK][NC];
    int       nw[NK][NC];
    int       dv[NC];
    int       m_acc[NK];
    int       m_n, m_shift, m_cnt;
    bit       m_relu, m_run;
    logic [NK-1:0] m_sat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        i_data_val   = 1'b0;
        i_weight_val = 1'b0;
        i_conf_val   = 1'b0;
    endtask

    task automatic model_beat();
        int   s;
        int   r;
        exp_t e;
        for (int k = 0; k < NK; k++) begin
            s = 0;
            for (int c = 0; c < NC; c++) s += dv[c] * m_w[k][c];
            m_acc[k] = (m_cnt == 0) ? s : m_acc[k] + s;
        end
        m_cnt++;
        if (m_cnt == m_n) begin
            m_cnt  = 0;
            e.psum = '0;
            e.due  = cyc + 4;
            for (int k = 0; k < NK; k++) begin
                r = m_acc[k] >>> m_shift;
                if (m_relu && r < 0) r = 0;
                if (r > 127) begin
                    r = 127;
                    m_sat[k] = 1'b1;
                end else if (r < -128) begin
                    r = -128;
                    m_sat[k] = 1'b1;
                end
                e.psum[k*BW +: BW] = 8'(r);
            end
            e.sat = m_sat;
            exp_q.push_back(e);
        end
    endtask

    task automatic load_weights();
        for (int k = 0; k < NK; k++) begin
            for (int c = 0; c < NC; c++) begin
                i_weight[(k*NC+c)*BW +: BW] = 8'(nw[k][c]);
                m_w[k][c] = nw[k][c];
            end
        end
        i_weight_val = 1'b1;
    endtask

    task automatic beat();
        for (int c = 0; c < NC; c++) i_data[c*BW +: BW] = 8'(dv[c]);
        i_data_val = 1'b1;
        if (m_run) model_beat();
    endtask

    task automatic cfg(input int n, input int sh, input bit relu);
        repeat (5) tick();
        i_conf_cnt   = 8'(n);
        i_conf_shift = 5'(sh);
        i_conf_relu  = relu;
        i_conf_val   = 1'b1;
        m_n     = (n == 0) ? 1 : n;
        m_shift = sh;
        m_relu  = relu;
        m_cnt   = 0;
        m_sat   = '0;
        m_run   = 1'b1;
        tick();
        check("ready_after_cfg", o_ready, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        check("drain_pending", exp_q.size(), 0);
    endtask

    task automatic t1_weights();
        nw = '{'{1, 1, 1}, '{2, 0, 0}, '{-1, -1, -1}, '{0, 0, 1}};
        load_weights();
        tick();
    endtask

    always @(negedge clk) begin
        if (!rst && o_psum_val) begin
            if (exp_q.size() == 0) begin
                check("pulse_unexpected", o_psum_val, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("psum", o_psum, mon_e.psum);
                check("sat", o_sat, mon_e.sat);
                check("latency", cyc, mon_e.due);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        i_conf_cnt = '0; i_conf_shift = '0; i_conf_relu = 1'b0; i_conf_val = 1'b0;
        i_data = '0; i_data_val = 1'b0; i_weight = '0; i_weight_val = 1'b0;
        m_w = '{default: 0}; nw = '{default: 0}; dv = '{default: 0}; m_acc = '{default: 0};
        m_n = 1; m_shift = 0; m_cnt = 0; m_relu = 1'b0; m_run = 1'b0; m_sat = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", o_ready, 0);
        check("rst_psum", o_psum, 0);
        check("rst_psum_val", o_psum_val, 0);
        check("rst_sat", o_sat, 0);
        check("rst_conf_err", o_conf_err, 0);
        rst = 1'b0;
        tick();

        // Single-beat window with the reference weight set
        t1_weights();
        cfg(1, 0, 0);
        dv = '{1, 2, 3};
        beat();
        tick();
        drain();
        check("t1_psum", o_psum, 32'h03FA0206);
        check("t1_sat", o_sat, 0);
        check("t1_pulse_low", o_psum_val, 0);

        // Two back-to-back three-beat windows
        cfg(3, 0, 0);
        for (int i = 0; i < 6; i++) begin
            dv = (i < 3) ? '{1, 1, 1} : '{2, 2, 2};
            beat();
            tick();
        end
        drain();
        check("t2_k0", o_psum[7:0], 8'd18);

        // Saturation, sticky flag, then shift-down on the same input
        nw[0] = '{127, 127, 127};
        load_weights();
        tick();
        cfg(1, 0, 0);
        dv = '{127, 127, 127};
        beat();
        tick();
        drain();
        check("t3_k0_sat", o_psum[7:0], 8'h7F);
        check("t3_sat0", o_sat[0], 1);
        repeat (3) tick();
        check("t3_sat0_sticky", o_sat[0], 1);
        cfg(1, 10, 0);
        check("t3_sat_cleared", o_sat, 0);
        beat();
        tick();
        drain();
        check("t3_k0_shift", o_psum[7:0], 8'd47);
        check("t3_no_sat", o_sat, 0);

        // ReLU off and on
        t1_weights();
        cfg(1, 0, 0);
        dv = '{1, 2, 3};
        beat();
        tick();
        drain();
        check("t4_k2_norelu", o_psum[23:16], 8'hFA);
        cfg(1, 0, 1);
        beat();
        tick();
        drain();
        check("t4_k2_relu", o_psum[23:16], 8'h00);

        // Config strobe mid-window is rejected
        cfg(3, 0, 0);
        dv = '{1, 1, 1};
        beat();
        tick();
        i_conf_cnt = 8'd1; i_conf_shift = 5'd3; i_conf_relu = 1'b1; i_conf_val = 1'b1;
        tick();
        check("t5_conf_err", o_conf_err, 1);
        tick();
        check("t5_conf_err_pulse", o_conf_err, 0);
        beat();
        tick();
        beat();
        tick();
        drain();
        check("t5_k0_old_cfg", o_psum[7:0], 8'd9);

        // Reset in the middle of a window
        cfg(3, 0, 0);
        dv = '{4, 4, 4};
        beat();
        tick();
        beat();
        tick();
        rst = 1'b1;
        #1;
        check("t6_ready", o_ready, 0);
        check("t6_psum_val", o_psum_val, 0);
        check("t6_psum", o_psum, 0);
        m_run = 1'b0; m_cnt = 0; m_sat = '0; m_acc = '{default: 0}; m_w = '{default: 0};
        repeat (2) tick();
        rst = 1'b0;
        dv = '{5, 5, 5};
        beat();
        tick();
        check("t6_idle_ready", o_ready, 0);
        repeat (6) tick();
        t1_weights();
        cfg(1, 0, 0);
        dv = '{1, 2, 3};
        beat();
        tick();
        drain();
        check("t6_fresh_psum", o_psum, 32'h03FA0206);

        // Randomized windows, including weight loads coincident with beats
        for (int seg = 0; seg < 8; seg++) begin
            cfg(int'($urandom_range(0, 4)), int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    for (int k = 0; k < NK; k++)
                        for (int c = 0; c < NC; c++)
                            nw[k][c] = int'($urandom_range(0, 255)) - 128;
                    load_weights();
                end
                if ($urandom_range(0, 3) != 0) begin
                    for (int c = 0; c < NC; c++) dv[c] = int'($urandom_range(0, 255)) - 128;
                    beat();
                end
                tick();
            end
            while (m_cnt != 0) begin
                for (int c = 0; c < NC; c++) dv[c] = int'($urandom_range(0, 255)) - 128;
                beat();
                tick();
            end
            drain();
        end

        repeat (5) tick();
        check("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/conv2d_core_acc.md
# conv2d_core_acc

Parametrised next-generation accelerator core: per-beat multiply of a NUM_CHANNEL-wide data vector against NUM_KERNEL weight vectors, channel reduction, and accumulation of a configurable number of beats per output window. Each finished window is arithmetic-shifted, optionally ReLU'd and saturated to BIT_WIDTH per kernel. It sits between the line buffer / DMA front end and the output writer, replacing the fixed 3-channel/4-kernel engine-plus-accumulator pair.

## Interface
- BIT_WIDTH, 8, signed data/weight/output element width
- NUM_CHANNEL, 3, channels per data beat
- NUM_KERNEL, 4, kernels computed in parallel
- ACC_WIDTH, 32, signed accumulator width per kernel
- CNT_WIDTH, 8, width of window-length config
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_conf_cnt  in  CNT_WIDTH  beats per window N (0 treated as 1)
- i_conf_shift  in  5  arithmetic right shift applied to the accumulator
- i_conf_relu  in  1  1 = clamp negative results to 0
- i_conf_val  in  1  config load strobe
- i_data  in  BIT_WIDTH*NUM_CHANNEL  channel c at [c*BIT_WIDTH +: BIT_WIDTH]
- i_data_val  in  1  data beat valid
- i_weight  in  BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL  kernel k, channel c at [(k*NUM_CHANNEL+c)*BIT_WIDTH +: BIT_WIDTH]
- i_weight_val  in  1  weight register load strobe
- o_ready  out  1  data beats accepted
- o_psum  out  BIT_WIDTH*NUM_KERNEL  kernel k result at [k*BIT_WIDTH +: BIT_WIDTH]
- o_psum_val  out  1  one-cycle pulse per completed window
- o_sat  out  NUM_KERNEL  sticky per-kernel saturation flag
- o_conf_err  out  1  one-cycle pulse: config strobe rejected

## Operation
- States: IDLE (o_ready=0), RUN (o_ready=1). Reset -> IDLE.
- IDLE + i_conf_val: latch cnt/shift/relu, clear o_sat, -> RUN.
- RUN + i_conf_val: accepted only if beat counter = 0 and pipeline empty (no beat in stages 1-2); then reload config, clear o_sat, stay RUN. Otherwise config ignored, o_conf_err pulses next cycle.
- Weight register loads on any cycle with i_weight_val; a data beat in the same cycle uses the new i_weight (bypass).
- Beat accepted when i_data_val && o_ready. i_data_val in IDLE is dropped.
- Stage 1: NUM_CHANNEL*NUM_KERNEL signed products, 2*BIT_WIDTH each, registered.
- Stage 2: per-kernel channel sum (2*BIT_WIDTH+clog2(NUM_CHANNEL) bits, sign-extended to ACC_WIDTH). First beat of window loads acc = sum; later beats acc += sum. Accumulator wraps two's complement (sizing is the integrator's responsibility).
- Beat counter counts accepted beats 0..N-1, wraps to 0 on the Nth; Nth beat is flagged "last" down the pipe.
- Stage 3 (on last): r = acc >>> shift (floor); if relu and r<0, r=0; saturate to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1]; set o_sat[k] if clamped. Register o_psum, pulse o_psum_val.
- Back-to-back windows without bubble: first beat of window w+1 may enter stage 2 the cycle after last beat of w.
- No backpressure on output; consumer must accept every o_psum_val.

## Timing
- Reset values: o_ready=0, o_psum=0, o_psum_val=0, o_sat=0, o_conf_err=0; accumulators, counter, weight register, config and pipeline valids cleared.
- Config accepted at edge t -> o_ready=1 from t+1.
- Last beat of window accepted at edge t -> o_psum_val high during cycle after edge t+3 (latency 3), o_psum stable until next window's result.
- o_psum_val max rate: one per cycle when N=1.
- Reset asserted mid-window: all in-flight beats and partial sums discarded, no o_psum_val, state IDLE immediately.

## Test plan
- Config N=1, shift 0, relu 0; weights kernel0=(1,1,1), kernel1=(2,0,0), kernel2=(-1,-1,-1), kernel3=(0,0,1); data (1,2,3) -> 3 cycles later o_psum = {3,-6,2,6} (k3..k0), o_psum_val one cycle, o_sat=0.
- N=3, kernel0 weights (1,1,1), data (1,1,1) x3 back-to-back, then (2,2,2) x3 -> two pulses: 9 then 18; no bubble between windows.
- Saturation: N=1, data (127,127,127), kernel0 weights (127,127,127) -> kernel0 output 127, o_sat[0]=1 and stays until next accepted config; shift 10 on same input -> 47, no new saturation.
- ReLU: kernel2 weights (-1,-1,-1), data (1,2,3): relu=0 -> -6; relu=1 -> 0.
- i_conf_val mid-window (after beat 1 of N=3) -> o_conf_err pulse, config unchanged, window completes with old N.
- Reset after 2 of 3 beats -> o_ready=0, no o_psum_val; reconfigure and run N=1 window -> correct fresh result (no stale accumulation).
